// File: rtl/ifetch_unit.sv
// DLX instruction fetch stage: PC register, imem req/ready handshake and next-PC selection.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned targets (sticky misalign flag + terminal HALT).
module ifetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [0:31] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [0:31] imem_rdata_i,
  output logic [0:31] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_accept_i,
  input  logic        jump_i,
  input  logic        regToPC_i,
  input  logic        branch_i,
  input  logic        branchZero_i,
  input  logic [0:31] rs1_val_i,
  output logic [0:31] pc_plus4_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
`ifdef IFETCH_ALIGN_CHECK_EN
    , ST_HALT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] instr_q, instr_d;
  logic [0:31] pc_plus4;
  logic [0:31] jump_tgt;
  logic [0:31] branch_tgt;
  logic [0:31] next_raw;
  logic [0:31] next_pc;
  logic        taken;
  logic        accept_fire;

  assign accept_fire = (state_q == ST_VALID) && instr_accept_i;

  // Bits [0:31] are MSB-first, so instr[6] / instr[16] are the offset sign bits.
  assign pc_plus4   = pc_q + 32'd4;
  assign jump_tgt   = pc_plus4 + {{6{instr_q[6]}}, instr_q[6:31]};
  assign branch_tgt = pc_plus4 + {{16{instr_q[16]}}, instr_q[16:31]};
  assign taken      = branchZero_i ? (rs1_val_i == 32'd0) : (rs1_val_i != 32'd0);

  always_comb begin
    next_raw = pc_plus4;
    if (regToPC_i) begin
      next_raw = rs1_val_i;
    end else if (jump_i) begin
      next_raw = jump_tgt;
    end else if (branch_i && taken) begin
      next_raw = branch_tgt;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q, misalign_d;

  assign next_pc    = next_raw;
  assign misaligned = |next_raw[30:31];
  assign misalign_d = misalign_q | (accept_fire && misaligned);
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign next_pc    = next_raw & 32'hFFFF_FFFC;
  assign misalign_o = 1'b0;
`endif

  assign pc_d    = accept_fire ? next_pc : pc_q;
  assign instr_d = ((state_q == ST_FETCH) && imem_ready_i) ? imem_rdata_i : instr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (imem_ready_i) state_d = ST_VALID;
      ST_VALID: begin
        if (instr_accept_i) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          state_d = misaligned ? ST_HALT : ST_FETCH;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      ST_HALT:  state_d = ST_HALT;
`endif
      default:  state_d = ST_RST;
    endcase
  end

  always_comb begin
    imem_req_o    = (state_q == ST_FETCH);
    instr_valid_o = (state_q == ST_VALID);
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_plus4_o  = pc_plus4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus pushes expected {instr, pc_plus4} per fetch,
// a monitor pops on every newly presented instruction. Honours IFETCH_ALIGN_CHECK_EN.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrAccept;
  logic        jump;
  logic        regToPC;
  logic        branch;
  logic        branchZero;
  logic [31:0] rs1Val;
  logic [31:0] pcPlus4;
  logic        misalign;

  int          tests = 0;
  int          failures = 0;
  int          waitCycles = 0;
  int          reqAge = 0;
  logic        prevValid = 1'b0;
  logic [63:0] expQ[$];
  logic [63:0] expEntry;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .imem_req_o     (imemReq),
    .imem_addr_o    (imemAddr),
    .imem_ready_i   (imemReady),
    .imem_rdata_i   (imemRdata),
    .instr_o        (instr),
    .instr_valid_o  (instrValid),
    .instr_accept_i (instrAccept),
    .jump_i         (jump),
    .regToPC_i      (regToPC),
    .branch_i       (branch),
    .branchZero_i   (branchZero),
    .rs1_val_i      (rs1Val),
    .pc_plus4_o     (pcPlus4),
    .misalign_o     (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction memory contents; unlisted addresses return a tagged filler word.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0010: return 32'h1000_FFF8;
      32'h0000_0014: return 32'h1400_0008;
      32'h0000_0020: return 32'h0800_001C;
      32'h0000_0100: return 32'h0BFF_FFF0;
      default:       return 32'hA500_0000 ^ a;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Memory responder: ready after waitCycles cycles of an outstanding request;
  // while no request is pending ready idles high so stale readies get exercised.
  always @(negedge clk) begin
    if (imemReq) begin
      if (reqAge >= waitCycles) begin
        imemReady = 1'b1;
        imemRdata = memRead(imemAddr);
      end else begin
        imemReady = 1'b0;
      end
      reqAge++;
    end else begin
      imemReady = 1'b1;
      reqAge = 0;
    end
  end

  // Monitor: every rising instr_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    if (instrValid === 1'b1 && prevValid !== 1'b1) begin
      if (expQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected instr: got 0x%08h at pc_plus4 0x%08h, expected none", instr, pcPlus4);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("instr", instr, expEntry[63:32]);
        checkOutput("pc_plus4", pcPlus4, expEntry[31:0]);
      end
    end
    prevValid = instrValid;
  end

  task automatic pushFetch(input logic [31:0] addr);
    expQ.push_back({memRead(addr), addr + 32'd4});
  endtask

  // Accept the presented instruction with the given controls for one cycle.
  task automatic applyStimulus(input logic [31:0] nextAddr, input bit j, input bit r, input bit b,
                               input bit bz, input logic [31:0] rs1, input bit expectFetch);
    if (expectFetch) pushFetch(nextAddr);
    jump        = j;
    regToPC     = r;
    branch      = b;
    branchZero  = bz;
    rs1Val      = rs1;
    instrAccept = 1'b1;
    @(negedge clk);
    instrAccept = 1'b0;
    jump        = 1'b0;
    regToPC     = 1'b0;
    branch      = 1'b0;
    branchZero  = 1'b0;
    rs1Val      = 32'd0;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (instrValid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (instrValid !== 1'b1) begin
      tests++;
      failures++;
      $display("[TB] FAIL %s timeout: instr_valid got %b, expected 1", tag, instrValid);
    end
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    pushFetch(32'h0);
    @(negedge clk);
    checkOutput("idle req", {31'd0, imemReq}, 32'd0);
    checkOutput("idle valid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    checkOutput("first req", {31'd0, imemReq}, 32'd1);
    checkOutput("first addr", imemAddr, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1;
    instrAccept = 1'b0;
    jump = 1'b0;
    regToPC = 1'b0;
    branch = 1'b0;
    branchZero = 1'b0;
    rs1Val = 32'd0;
    imemReady = 1'b1;
    imemRdata = 32'd0;
    #1 rst_n = 1'b0;

    @(negedge clk);
    checkOutput("reset req", {31'd0, imemReq}, 32'd0);
    checkOutput("reset valid", {31'd0, instrValid}, 32'd0);
    checkOutput("reset instr", instr, 32'd0);
    checkOutput("reset misalign", {31'd0, misalign}, 32'd0);
    releaseReset();
    waitValid("first fetch");

    // Sequential walk 0x0 -> 0x10.
    for (int a = 0; a < 16; a += 4) begin
      applyStimulus(a + 4, 0, 0, 0, 0, 32'd0, 1);
      waitValid("sequential");
    end

    applyStimulus(32'h0C, 0, 0, 1, 1, 32'd0, 1);
    waitValid("beqz taken");
    applyStimulus(32'h10, 0, 0, 0, 0, 32'd0, 1);
    waitValid("seq to 0x10");
    applyStimulus(32'h14, 0, 0, 1, 1, 32'd1, 1);
    waitValid("beqz not taken");
    applyStimulus(32'h20, 0, 0, 1, 0, 32'd5, 1);
    waitValid("bnez taken");
    applyStimulus(32'h40, 1, 0, 0, 0, 32'd0, 1);
    waitValid("jump fwd");

    checkOutput("jalr link", pcPlus4, 32'h44);
    waitCycles = 3;
    applyStimulus(32'h100, 1, 1, 0, 0, 32'h100, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("wait req", {31'd0, imemReq}, 32'd1);
      checkOutput("wait addr", imemAddr, 32'h100);
    end
    waitCycles = 0;
    waitValid("jalr");

    for (int i = 0; i < 5; i++) begin
      checkOutput("hold valid", {31'd0, instrValid}, 32'd1);
      checkOutput("hold req", {31'd0, imemReq}, 32'd0);
      checkOutput("hold instr", instr, 32'h0BFF_FFF0);
      @(negedge clk);
    end
    applyStimulus(32'hF4, 1, 0, 0, 0, 32'd0, 1);
    waitValid("jump back");

    applyStimulus(32'hFFFF_FFFC, 0, 1, 0, 0, 32'hFFFF_FFFC, 1);
    waitValid("jr top");
    applyStimulus(32'h0, 0, 0, 0, 0, 32'd0, 1);
    waitValid("wrap");

    // Abandon a pending fetch of 0x4 with reset.
    waitCycles = 10;
    applyStimulus(32'h4, 0, 0, 0, 0, 32'd0, 0);
    checkOutput("pending req", {31'd0, imemReq}, 32'd1);
    checkOutput("pending addr", imemAddr, 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset req", {31'd0, imemReq}, 32'd0);
    checkOutput("midreset valid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    waitCycles = 0;
    releaseReset();
    waitValid("refetch");

`ifdef IFETCH_ALIGN_CHECK_EN
    applyStimulus(32'h102, 0, 1, 0, 0, 32'h102, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("halt misalign", {31'd0, misalign}, 32'd1);
      checkOutput("halt req", {31'd0, imemReq}, 32'd0);
      checkOutput("halt valid", {31'd0, instrValid}, 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("misalign cleared", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    releaseReset();
    waitValid("post halt");
`else
    applyStimulus(32'h100, 0, 1, 0, 0, 32'h102, 1);
    waitValid("jr unaligned");
    checkOutput("misalign tied", {31'd0, misalign}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
